uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Next-generation UART receive engine with run-time frame format selection and an output FIFO:
- 5-8 data bits, optional odd/even parity, 1 or 2 stop bits.
- 3-sample majority voting per bit.
- Per-frame parity, framing and break flags.
- Output through a FIFO with valid/ready handshake and sticky overrun.

It sits between the synchronised rx pin and the AXI-Lite register front end, replacing the fixed-format receiver.

Parameters:
DIV_SIZE, 16, width of baud divisor (clocks per bit).
FIFO_DEPTH, 4, receive FIFO entries; power of two, >=2.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  receiver enable
data_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8
parity_en_i  in  1  parity bit present
parity_odd_i  in  1  parity mode: 1=odd, 0=even
stop_bits_i  in  1  stop bits: 0=1 bit, 1=2 bits
baud_div_i  in  DIV_SIZE  clocks per bit, legal >=4
rx_i  in  1  asynchronous serial input
rx_data_o  out  8  FIFO head data, right-justified, unused MSBs zero
rx_perr_o  out  1  FIFO head parity error
rx_ferr_o  out  1  FIFO head framing error
rx_brk_o  out  1  FIFO head break
rx_valid_o  out  1  FIFO not empty
rx_ready_i  in  1  consumer pops head when rx_valid_o & rx_ready_i
overrun_o  out  1  sticky: frame dropped because FIFO was full
overrun_clr_i  in  1  clears overrun_o
busy_o  out  1  FSM not in IDLE

Behaviour:
Reset:
- rst_i sampled on clk_i. Takes priority over everything, including mid-frame.
- FSM -> IDLE, FIFO emptied, 3-flop rx synchroniser preset to 1.
- All outputs 0.

Synchroniser and bit timing:
- rx_i passes through 3 flops; "rx" below is the synchronised bit.
- Each bit is timed by counter c = 0..baud_div_i-1. H = baud_div_i>>1.
- Samples are taken at c = H-1, H, H+1; bit value = majority of the 3.
- At c = baud_div_i-1 the counter resets to 0 and the FSM advances to the next bit.

Config latch:
- data_bits_i, parity_en_i, parity_odd_i, stop_bits_i and baud_div_i are latched at the start edge.
- Mid-frame changes to these inputs have no effect on the current frame.

States:
- IDLE: when en_i & rx==0, latch config, c = 0 (the edge cycle is c = 0), go START.
- START: at c = H+1, if the voted start bit is 1 this is a false start -> IDLE, no push. Otherwise continue to the end of the bit, then go DATA.
- DATA:
  - Receive N bits LSB first into an 8-bit shift register.
  - Result is right-justified and zero-extended.
  - After bit N-1 go PARITY if enabled, else STOP.
- PARITY:
  - perr = XOR(data bits, parity bit) != parity_odd.
  - Even mode: total XOR must be 0. Odd mode: total XOR must be 1.
- STOP:
  - ferr = 1 if any voted stop bit is 0; with 2 stop bits, both are checked.
  - Frame completes at c = H+1 of the last stop bit. The frame is not held for the rest of the stop bit.
  - On completion, push {brk, ferr, perr, data}.
  - Then go IDLE if ferr==0, else WAIT_HIGH.
- WAIT_HIGH: stay until rx==1, then IDLE. This prevents a held-low line from generating repeated frames.

Break:
- brk = 1 when all data bits are 0, the parity bit (if present) is 0 and the first stop bit is 0.
- brk implies ferr = 1. perr is reported as computed.

en_i deasserted in any non-IDLE state:
- Next state is IDLE; the frame is discarded with no push.
- FIFO contents and overrun_o are retained.

FIFO:
- First-word-fall-through. Head flags and data are valid whenever rx_valid_o = 1.
- Latency: push at cycle T into an empty FIFO gives rx_valid_o = 1 at T+1.
- Pop when rx_valid_o & rx_ready_i. Pop on empty is ignored.
- A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Full with simultaneous push and pop: head advances, new frame is written, count is unchanged.
- Push when full with no pop: frame dropped, overrun_o set next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap. A separate count or extra pointer bit distinguishes full from empty.

Overrun:
- overrun_clr_i clears overrun_o. Simultaneous set and clear: set wins.

busy_o = (state != IDLE). It is registered from the state register.

Test Plan:
- 8N1, baud_div=16, send 0xA5, rx_ready_i=1 -> one entry 0xA5, perr=ferr=brk=0; rx_valid_o high exactly one cycle.
- 7 data bits, even parity, 1 stop; send 0x35 with parity bit 1 (correct is 0) -> data 0x35, perr=1. Repeat with odd parity, send 0x35 with parity bit 1 -> perr=0.
- 8N1, div=16; low pulse of 4 clocks -> no push, busy_o back to 0. A 1-clock low glitch at the centre of bit 3 of 0xFF -> 0xFF received cleanly.
- 8N1; rx held low for 20 bit times, then released -> exactly one entry: 0x00, ferr=1, brk=1. No further entries until rx high; the next frame 0x5A is received normally.
- FIFO_DEPTH=4, rx_ready_i=0; send 0x01..0x05 -> 4 entries, overrun_o=1, 0x05 lost. Pop all in order 0x01..0x04. Pulse overrun_clr_i -> overrun_o=0. Full FIFO with pop and push in the same cycle -> no overrun.
- 2 stop bits, second stop bit 0 -> ferr=1, brk=0. Deassert en_i in the middle of a data bit -> no entry, busy_o=0 next cycle. Assert rst_i mid-frame -> all outputs 0 and FIFO empty after one clock.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with run-time frame format, 3-sample majority voting and a
// first-word-fall-through output FIFO with sticky overrun.
module uart_rx_fifo #(
    parameter int unsigned DIV_SIZE   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [1:0]          data_bits_i,
    input  logic                parity_en_i,
    input  logic                parity_odd_i,
    input  logic                stop_bits_i,
    input  logic [DIV_SIZE-1:0] baud_div_i,
    input  logic                rx_i,
    output logic [7:0]          rx_data_o,
    output logic                rx_perr_o,
    output logic                rx_ferr_o,
    output logic                rx_brk_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                overrun_o,
    input  logic                overrun_clr_i,
    output logic                busy_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0]        FifoFull = (PtrW+1)'(FIFO_DEPTH);
    localparam logic [DIV_SIZE-1:0]  CntOne   = DIV_SIZE'(1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StParity   = 3'd3;
    localparam logic [2:0] StStop     = 3'd4;
    localparam logic [2:0] StWaitHigh = 3'd5;

    logic [2:0]          sync_q;
    logic [2:0]          state_q, state_d;
    logic [DIV_SIZE-1:0] cnt_q, cnt_d;
    logic [DIV_SIZE-1:0] div_q, div_d;
    logic [1:0]          dbits_q, dbits_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic                stop2_q, stop2_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                pbit_q, pbit_d;
    logic                s0_q, s0_d, s1_q, s1_d;
    logic                ferr_q, ferr_d;
    logic                brk_q, brk_d;
    logic                stop_idx_q, stop_idx_d;

    logic                rx, vote, last_data, perr, brk_now, stop_ferr, push;
    logic [DIV_SIZE-1:0] half;
    logic                at_s0, at_s1, at_vote, at_end;
    logic [10:0]         push_word;

    assign rx        = sync_q[2];
    assign half      = div_q >> 1;
    assign at_s0     = (cnt_q == half - CntOne);
    assign at_s1     = (cnt_q == half);
    assign at_vote   = (cnt_q == half + CntOne);
    assign at_end    = (cnt_q == div_q - CntOne);
    assign vote      = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
    assign last_data = (bit_idx_q == ({1'b0, dbits_q} + 3'd4));
    assign perr      = par_en_q & ((^shreg_q ^ pbit_q) != par_odd_q);
    assign stop_ferr = ferr_q | ~vote;
    // Break is judged on the first stop bit; pbit_q stays 0 when no parity bit.
    assign brk_now   = stop_idx_q ? brk_q : ((shreg_q == 8'h00) & ~pbit_q & ~vote);
    assign push_word = {brk_now, stop_ferr, perr, shreg_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = at_end ? '0 : cnt_q + CntOne;
        div_d      = div_q;
        dbits_d    = dbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        pbit_d     = pbit_q;
        s0_d       = at_s0 ? rx : s0_q;
        s1_d       = at_s1 ? rx : s1_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        stop_idx_d = stop_idx_q;
        push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (en_i && !rx) begin
                    // The edge cycle itself counts as c = 0.
                    cnt_d      = CntOne;
                    div_d      = baud_div_i;
                    dbits_d    = data_bits_i;
                    par_en_d   = parity_en_i;
                    par_odd_d  = parity_odd_i;
                    stop2_d    = stop_bits_i;
                    bit_idx_d  = 3'd0;
                    shreg_d    = 8'h00;
                    pbit_d     = 1'b0;
                    ferr_d     = 1'b0;
                    brk_d      = 1'b0;
                    stop_idx_d = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (at_vote && vote) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_vote) shreg_d[bit_idx_q] = vote;
                if (at_end) begin
                    if (last_data) state_d = par_en_q ? StParity : StStop;
                    else           bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StParity: begin
                if (at_vote) pbit_d = vote;
                if (at_end)  state_d = StStop;
            end
            StStop: begin
                if (at_vote) begin
                    ferr_d = stop_ferr;
                    brk_d  = brk_now;
                    if (!stop2_q || stop_idx_q) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        state_d = stop_ferr ? StWaitHigh : StIdle;
                    end
                end else if (at_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            StWaitHigh: begin
                cnt_d = '0;
                if (rx) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
        if (!en_i && state_q != StIdle) begin
            state_d = StIdle;
            cnt_d   = '0;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q     <= 3'b111;
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            dbits_q    <= 2'b00;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            pbit_q     <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], rx_i};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            dbits_q    <= dbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            pbit_q     <= pbit_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    assign busy_o = (state_q != StIdle);

    // Output FIFO, {brk, ferr, perr, data[7:0]} per entry.
    logic [10:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            pop, full, accept, ovr_set;
    logic [10:0]     head;

    assign pop     = rx_valid_o & rx_ready_i;
    assign full    = (count_q == FifoFull);
    assign accept  = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (!accept && pop) count_d = count_q - 1'b1;
        overrun_d = ovr_set | (overrun_q & ~overrun_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) mem_q[wr_ptr_q] <= push_word;
    end

    assign head       = mem_q[rd_ptr_q];
    assign rx_valid_o = (count_q != '0);
    assign rx_data_o  = rx_valid_o ? head[7:0] : 8'h00;
    assign rx_perr_o  = rx_valid_o & head[8];
    assign rx_ferr_o  = rx_valid_o & head[9];
    assign rx_brk_o   = rx_valid_o & head[10];
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected frames, a monitor
// pops and compares on every valid/ready handshake.
module tb_uart_rx_fifo;

    localparam int DIV = 16;

    logic        clk_i = 1'b0;
    logic        rst_i, en_i, parity_en_i, parity_odd_i, stop_bits_i, rx_i;
    logic [1:0]  data_bits_i;
    logic [15:0] baud_div_i;
    logic [7:0]  rx_data_o;
    logic        rx_perr_o, rx_ferr_o, rx_brk_o, rx_valid_o, rx_ready_i;
    logic        overrun_o, overrun_clr_i, busy_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          valid_cycles = 0;
    logic [10:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    uart_rx_fifo #(.DIV_SIZE(16), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_bits_i(data_bits_i),
        .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop_bits_i(stop_bits_i),
        .baud_div_i(baud_div_i), .rx_i(rx_i), .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o),
        .rx_ferr_o(rx_ferr_o), .rx_brk_o(rx_brk_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i),
        .busy_o(busy_o)
    );

    // Monitor: every handshake pops one expected {brk, ferr, perr, data}.
    initial begin
        logic [10:0] exp;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (rx_valid_o) valid_cycles++;
                if (rx_valid_o && rx_ready_i) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_entry got=%h required=none",
                                 {rx_brk_o, rx_ferr_o, rx_perr_o, rx_data_o});
                    end else begin
                        exp = exp_q.pop_front();
                        if ({rx_brk_o, rx_ferr_o, rx_perr_o, rx_data_o} !== exp) begin
                            n_fail++;
                            $display("FAIL rx_entry got=%h required=%h",
                                     {rx_brk_o, rx_ferr_o, rx_perr_o, rx_data_o}, exp);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pb,
                              input bit st0, input bit st1, input bit two_stop);
        rx_i = 1'b0;
        clocks(DIV);
        for (int i = 0; i < nb; i++) begin
            rx_i = d[i];
            clocks(DIV);
        end
        if (pen) begin
            rx_i = pb;
            clocks(DIV);
        end
        rx_i = st0;
        clocks(DIV);
        if (two_stop) begin
            rx_i = st1;
            clocks(DIV);
        end
        rx_i = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) clocks(1);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b1; rx_i = 1'b1; rx_ready_i = 1'b1; overrun_clr_i = 1'b0;
        data_bits_i = 2'b11; parity_en_i = 1'b0; parity_odd_i = 1'b0; stop_bits_i = 1'b0;
        baud_div_i = 16'(DIV);
        clocks(3);
        check("reset_outputs", {rx_valid_o, busy_o, overrun_o, rx_brk_o, rx_ferr_o,
                                rx_perr_o, rx_data_o}, 0);
        rst_i = 1'b0;
        clocks(8);

        // 8N1 0xA5, handshake lasts exactly one cycle
        valid_cycles = 0;
        exp_q.push_back({3'b000, 8'hA5});
        send_frame(8'hA5, 8, 0, 0, 1, 1, 0);
        clocks(2 * DIV);
        drain("drain_a5");
        check("valid_one_cycle", valid_cycles, 1);

        // 7E1 wrong parity, then 7O1 correct parity
        data_bits_i = 2'b10; parity_en_i = 1'b1; parity_odd_i = 1'b0;
        exp_q.push_back({3'b001, 8'h35});
        send_frame(8'h35, 7, 1, 1, 1, 1, 0);
        clocks(DIV);
        parity_odd_i = 1'b1;
        exp_q.push_back({3'b000, 8'h35});
        send_frame(8'h35, 7, 1, 1, 1, 1, 0);
        clocks(DIV);
        drain("drain_parity");
        data_bits_i = 2'b11; parity_en_i = 1'b0; parity_odd_i = 1'b0;

        // false start: 4-clock low pulse
        rx_i = 1'b0;
        clocks(4);
        rx_i = 1'b1;
        clocks(2 * DIV);
        check("false_start_busy", busy_o, 0);

        // 0xFF with a 1-clock glitch in the middle of data bit 3
        exp_q.push_back({3'b000, 8'hFF});
        for (int i = 0; i < 10; i++) begin
            rx_i = (i != 0);
            if (i == 4) begin
                clocks(8); rx_i = 1'b0; clocks(1); rx_i = 1'b1; clocks(7);
            end else begin
                clocks(DIV);
            end
        end
        rx_i = 1'b1;
        clocks(DIV);
        drain("drain_glitch");

        // line held low: one break entry, then silence until the line returns high
        exp_q.push_back({3'b110, 8'h00});
        rx_i = 1'b0;
        clocks(20 * DIV);
        check("break_wait_high_busy", busy_o, 1);
        check("break_single_entry", exp_q.size(), 0);
        rx_i = 1'b1;
        clocks(2 * DIV);
        check("after_break_busy", busy_o, 0);
        exp_q.push_back({3'b000, 8'h5A});
        send_frame(8'h5A, 8, 0, 0, 1, 1, 0);
        clocks(DIV);
        drain("drain_5a");

        // overrun: five frames into a 4-entry FIFO with no consumer
        rx_ready_i = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v <= 4) exp_q.push_back({3'b000, 8'(v)});
            send_frame(8'(v), 8, 0, 0, 1, 1, 0);
        end
        clocks(4);
        check("overrun_set", overrun_o, 1);
        check("full_valid", rx_valid_o, 1);
        rx_ready_i = 1'b1;
        drain("drain_overrun");
        rx_ready_i = 1'b0;
        clocks(2);
        check("overrun_sticky", overrun_o, 1);
        overrun_clr_i = 1'b1;
        clocks(1);
        overrun_clr_i = 1'b0;
        check("overrun_cleared", overrun_o, 0);

        // full FIFO: pop in the exact push cycle (start edge + 3 sync + 153)
        for (int v = 8'h11; v <= 8'h14; v++) begin
            exp_q.push_back({3'b000, 8'(v)});
            send_frame(8'(v), 8, 0, 0, 1, 1, 0);
        end
        exp_q.push_back({3'b000, 8'h15});
        fork
            send_frame(8'h15, 8, 0, 0, 1, 1, 0);
            begin
                clocks(156);
                rx_ready_i = 1'b1;
                clocks(1);
                rx_ready_i = 1'b0;
            end
        join
        clocks(4);
        check("push_pop_full_no_overrun", overrun_o, 0);
        check("push_pop_full_valid", rx_valid_o, 1);
        rx_ready_i = 1'b1;
        drain("drain_push_pop");

        // two stop bits, second one low
        stop_bits_i = 1'b1;
        exp_q.push_back({3'b010, 8'h3C});
        send_frame(8'h3C, 8, 0, 0, 1, 0, 1);
        clocks(2 * DIV);
        drain("drain_stop2");
        stop_bits_i = 1'b0;

        // en_i dropped mid data bit 3
        fork
            send_frame(8'hFF, 8, 0, 0, 1, 1, 0);
            begin
                clocks(4 * DIV + 8);
                check("abort_busy_before", busy_o, 1);
                en_i = 1'b0;
                clocks(1);
                check("abort_busy_after", busy_o, 0);
            end
        join
        en_i = 1'b1;
        clocks(2 * DIV);
        check("abort_no_entry", rx_valid_o, 0);

        // reset mid-frame with one entry already buffered
        rx_ready_i = 1'b0;
        exp_q.push_back({3'b000, 8'h77});
        send_frame(8'h77, 8, 0, 0, 1, 1, 0);
        clocks(4);
        check("pre_reset_valid", rx_valid_o, 1);
        fork
            send_frame(8'hFF, 8, 0, 0, 1, 1, 0);
            begin
                clocks(3 * DIV);
                rst_i = 1'b1;
                clocks(1);
                check("midframe_reset_outputs", {rx_valid_o, busy_o, overrun_o, rx_brk_o,
                                                 rx_ferr_o, rx_perr_o, rx_data_o}, 0);
                exp_q.delete();
                rst_i = 1'b0;
            end
        join
        clocks(2 * DIV);
        check("post_reset_idle", {rx_valid_o, busy_o}, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
